core_dispatch_ctrl: RTL and testbench
=====================================

Name: core_dispatch_ctrl

Overview:
- Sits directly downstream of the HPS memory-mapped control register block, in the core clock domain.
- Consumes its start level, clear level and per-core enable mask, and launches the enabled compute cores.
- Tracks per-core completion with a timeout, then raises the sticky `interrupt` that the control block reads back at address 1.
- Also reports a per-core fault mask and the run-length cycle count.

Parameters:
CORE_NUM, 4, number of compute cores dispatched
TIMEOUT, 16'd50000, cycles in RUN before the job is aborted as faulted
CNT_W, 16, width of the cycle counter and timeout counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
start  in  1  start level from control block (interrupt_internal); held high ~20 cycles; rising edge = job request
clear  in  1  clear level from control block (clear_interrupt); rising edge = interrupt acknowledge
core_en  in  CORE_NUM  per-core enable mask from control block
core_done  in  CORE_NUM  per-core completion pulses/levels from cores
core_start  out  CORE_NUM  one-cycle launch pulse per enabled core
busy  out  1  high in LAUNCH, RUN, DONE
interrupt  out  1  sticky job-complete flag to control block
core_fault  out  CORE_NUM  cores that had not completed at timeout
cycle_count  out  CNT_W  cycles from LAUNCH to completion, saturating

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset has priority over everything, including mid-job: state=IDLE and all outputs 0 (core_start, busy, interrupt, core_fault, cycle_count). Edge-detect history registers reset to 0; a start held high through reset release therefore triggers a job.
- Edge detection: registered copies start_q and clear_q. start_rise = start & ~start_q; clear_rise = clear & ~clear_q.
- Mask latch: on accepted start_rise, mask <= core_en. Later core_en changes have no effect until the next job.
- IDLE:
  - start_rise with core_en != 0 -> LAUNCH. Latch mask, clear seen and core_fault, cycle_count <= 0.
  - start_rise with core_en == 0 -> DONE directly. cycle_count=0, core_fault=0.
- LAUNCH (1 cycle): core_start = mask (registered output, high only this cycle). cycle_count <= 1. -> RUN.
- RUN:
  - Each cycle: seen <= seen | (core_done & mask). core_done on unmasked cores and outside LAUNCH/RUN is ignored. core_done is also sampled in the LAUNCH cycle.
  - cycle_count increments each cycle, saturating at 2^CNT_W-1.
  - If (seen | (core_done & mask)) == mask -> DONE.
  - Else if the timeout counter reaches TIMEOUT-1 -> DONE, with core_fault <= mask & ~(seen | core_done). Completion in the same cycle as timeout counts as completion (no fault for that core).
- DONE (1 cycle): interrupt <= 1. -> IDLE.
- Latency: start_rise sampled cycle N -> core_start high cycle N+1. Final core_done sampled cycle M -> DONE at M+1 -> interrupt high from M+2.
- interrupt priority:
  - Cleared only by clear_rise.
  - A set from DONE in the same cycle as clear_rise wins (interrupt stays 1).
  - Clear level held high does not re-clear later completions.
- Ignored / held values:
  - start_rise while busy is ignored (not queued).
  - core_fault and cycle_count hold until the next accepted start.
- busy = (state != IDLE).

Decomposition:
- Package core_dispatch_pkg: state enum (IDLE, LAUNCH, RUN, DONE, 2-bit encoding 0..3) and default constants for TIMEOUT and CNT_W.
- One natural sub-module, edge_rise_det: 1-bit rising-edge detector with synchronous reset, instantiated twice (start, clear).

Test Plan:
- Basic job: core_en=4'b1111; start high 20 cycles; cores return done at +5, +7, +9, +12 cycles after core_start -> core_start=4'b1111 for exactly 1 cycle; interrupt rises 2 cycles after last done; core_fault=0; cycle_count=13.
- Partial mask: core_en=4'b0101, done only on cores 0 and 2; spurious done on core 1 -> completes normally; core_start=4'b0101; core_fault=0.
- Timeout: TIMEOUT=100, core_en=4'b1111, core 3 never completes -> DONE after 100 RUN cycles; core_fault=4'b1000; interrupt=1.
- Empty mask and busy start: start with core_en=0 -> interrupt high 2 cycles later, cycle_count=0, no core_start. Second start rising edge during RUN of a real job -> ignored; only one core_start pulse seen.
- Clear semantics: clear rise while interrupt=1 -> interrupt=0 next cycle. Clear rise coinciding with DONE -> interrupt stays 1. Clear held high across a later completion -> interrupt still sets.
- Reset mid-RUN: assert reset for 1 cycle with 2 of 4 cores done -> all outputs 0, IDLE. New start runs a clean job with seen cleared.

Source files
------------

// File: rtl/core_dispatch_pkg.sv
// rtl/core_dispatch_pkg.sv - shared types and defaults for the core dispatch controller
package core_dispatch_pkg;

    // Dispatch sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_TIMEOUT = 50000;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/core_dispatch_ctrl_edge.sv
// rtl/core_dispatch_ctrl_edge.sv - single-bit rising-edge detector
module edge_rise_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // History register; cleared by reset so a level held through reset reads as a new edge
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/core_dispatch_ctrl.sv
// rtl/core_dispatch_ctrl.sv - launches enabled cores, tracks completion with timeout, raises sticky interrupt
module core_dispatch_ctrl
    import core_dispatch_pkg::*;
#(
    parameter int CORE_NUM = 4,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                clear,
    input  logic [CORE_NUM-1:0] core_en,
    input  logic [CORE_NUM-1:0] core_done,
    output logic [CORE_NUM-1:0] core_start,
    output logic                busy,
    output logic                interrupt,
    output logic [CORE_NUM-1:0] core_fault,
    output logic [CNT_W-1:0]    cycle_count
);

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_n;
    logic                start_rise;
    logic                clear_rise;
    logic [CORE_NUM-1:0] mask;
    logic [CORE_NUM-1:0] seen;
    logic [CORE_NUM-1:0] seen_n;
    logic [CNT_W-1:0]    tmo_cnt;
    logic                all_done;
    logic                timeout_hit;

    edge_rise_det u_start_edge (
        .clk   (clk),
        .reset (reset),
        .d     (start),
        .rise  (start_rise)
    );

    edge_rise_det u_clear_edge (
        .clk   (clk),
        .reset (reset),
        .d     (clear),
        .rise  (clear_rise)
    );

    // Completion view including this cycle's done inputs, so a last-cycle done is never faulted
    assign seen_n      = seen | (core_done & mask);
    assign all_done    = (seen_n == mask);
    assign timeout_hit = (tmo_cnt == TMO_LAST);
    assign busy        = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; an empty enable mask skips straight to DONE
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_n = (core_en != '0) ? LAUNCH : DONE;
                end
            end
            LAUNCH: state_n = RUN;
            RUN: begin
                if (all_done || timeout_hit) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Job datapath: mask latch, completion tracking, counters, launch pulse, fault and interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            mask        <= '0;
            seen        <= '0;
            tmo_cnt     <= '0;
            core_start  <= '0;
            interrupt   <= 1'b0;
            core_fault  <= '0;
            cycle_count <= '0;
        end else begin
            core_start <= '0;

            // Setting from DONE outranks an acknowledge arriving in the same cycle
            if (state == DONE) begin
                interrupt <= 1'b1;
            end else if (clear_rise) begin
                interrupt <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_rise) begin
                        mask        <= core_en;
                        seen        <= '0;
                        core_fault  <= '0;
                        cycle_count <= '0;
                        core_start  <= core_en;
                    end
                end
                LAUNCH: begin
                    seen        <= seen_n;
                    tmo_cnt     <= '0;
                    cycle_count <= CNT_ONE;
                end
                RUN: begin
                    seen    <= seen_n;
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    if (!all_done && timeout_hit) begin
                        core_fault <= mask & ~seen_n;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_dispatch_ctrl.sv
// tb/tb_core_dispatch_ctrl.sv - scoreboard bench for core_dispatch_ctrl
module tb_core_dispatch_ctrl;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        clear;
    logic [3:0]  core_en;
    logic [3:0]  core_done;
    logic [3:0]  core_start;
    logic        busy;
    logic        interrupt;
    logic [3:0]  core_fault;
    logic [15:0] cycle_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  cs;
        logic [3:0]  fault;
        logic [15:0] cnt;
        int          int_k;
    } exp_t;

    exp_t sb[$];

    core_dispatch_ctrl #(
        .CORE_NUM (4),
        .TIMEOUT  (TMO),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .clear       (clear),
        .core_en     (core_en),
        .core_done   (core_done),
        .core_start  (core_start),
        .busy        (busy),
        .interrupt   (interrupt),
        .core_fault  (core_fault),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference model: k counts cycles after the launch cycle; a done at k=0 lands in LAUNCH
    task automatic push_expect(input logic [3:0] en, input int d[4]);
        exp_t e;
        int   comp;
        bit   all_ok;
        int   done_k;
        e.cs    = en;
        e.fault = '0;
        if (en == 4'h0) begin
            e.cnt   = 16'd0;
            e.int_k = 0;
        end else begin
            comp   = 0;
            all_ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (en[i]) begin
                    if (d[i] < 0) all_ok = 1'b0;
                    else if (d[i] > comp) comp = d[i];
                end
            end
            if (comp < 1) comp = 1;
            if (all_ok && comp <= TMO) begin
                done_k = comp;
            end else begin
                done_k = TMO;
                for (int i = 0; i < 4; i++) begin
                    if (en[i] && (d[i] < 0 || d[i] > TMO)) e.fault[i] = 1'b1;
                end
            end
            e.cnt   = 16'(done_k + 1);
            e.int_k = done_k + 1;
        end
        sb.push_back(e);
    endtask

    task automatic run_job(input string tag, input logic [3:0] en,
                           input int d0, input int d1, input int d2, input int d3,
                           input int start_len, input int restart_k);
        int         d[4];
        int         launches;
        logic [3:0] cs_seen;
        bit         got;
        exp_t       e;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;

        clear = 1'b1;
        step();
        chk({tag, "_pre_irq"}, 32'(interrupt), 32'd0);
        clear = 1'b0;
        step();

        push_expect(en, d);
        core_en = en;
        start   = 1'b1;
        step();
        core_en  = ~en;
        launches = (core_start != 4'h0) ? 1 : 0;
        cs_seen  = core_start;
        chk({tag, "_busy"}, 32'(busy), 32'd1);

        got = 1'b0;
        for (int k = 0; k < TMO + 20 && !got; k++) begin
            for (int i = 0; i < 4; i++) core_done[i] = (d[i] == k);
            start = (k + 1 < start_len) || (restart_k >= 0 && k >= restart_k);
            step();
            if (core_start != 4'h0) begin
                launches++;
                cs_seen = core_start;
            end
            if (interrupt) begin
                got = 1'b1;
                e = sb.pop_front();
                chk({tag, "_irq_cycle"}, 32'(k), 32'(e.int_k));
                chk({tag, "_fault"}, 32'(core_fault), 32'(e.fault));
                chk({tag, "_count"}, 32'(cycle_count), 32'(e.cnt));
                chk({tag, "_start_val"}, 32'(cs_seen), 32'(e.cs));
                chk({tag, "_launches"}, 32'(launches), (e.cs != 4'h0) ? 32'd1 : 32'd0);
                chk({tag, "_idle"}, 32'(busy), 32'd0);
            end
        end
        core_done = 4'h0;
        start     = 1'b0;
        if (!got) begin
            chk({tag, "_irq_seen"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        step();
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        clear     = 1'b0;
        core_en   = 4'h0;
        core_done = 4'h0;
        step();
        step();
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(interrupt), 32'd0);
        chk("rst_fault", 32'(core_fault), 32'd0);
        chk("rst_count", 32'(cycle_count), 32'd0);
        reset = 1'b0;
        step();

        run_job("basic",       4'hF,  5,  7,  9,  12, 20, -1);
        run_job("partial",     4'h5,  2,  1,  4,  -1, 20, -1);
        run_job("launch_done", 4'h3,  0,  0, -1,  -1, 20, -1);
        run_job("timeout",     4'hF,  3,  5,  7,  -1, 20, -1);
        run_job("tmo_edge",    4'h8, -1, -1, -1, TMO, 20, -1);
        run_job("empty",       4'h0, -1, -1, -1,  -1, 20, -1);
        run_job("busy_start",  4'hF,  5,  7,  9,  12,  3,  6);

        // Acknowledge edge clears; a held clear level does not swallow a later completion
        clear = 1'b1;
        step();
        chk("clr_rise", 32'(interrupt), 32'd0);
        core_en = 4'h0;
        start   = 1'b1;
        step();
        step();
        chk("clr_held_set", 32'(interrupt), 32'd1);
        step();
        step();
        chk("clr_held_stay", 32'(interrupt), 32'd1);
        start = 1'b0;
        clear = 1'b0;
        step();
        clear = 1'b1;
        step();
        chk("clr_rise2", 32'(interrupt), 32'd0);
        clear = 1'b0;
        step();

        // Acknowledge edge landing in the DONE cycle loses to the set
        start = 1'b1;
        step();
        clear = 1'b1;
        step();
        chk("clr_vs_done", 32'(interrupt), 32'd1);
        start = 1'b0;
        clear = 1'b0;
        step();

        // Reset mid-job with two cores done
        clear = 1'b1;
        step();
        clear   = 1'b0;
        core_en = 4'hF;
        start   = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            core_done = (k == 1) ? 4'h1 : (k == 2) ? 4'h2 : 4'h0;
            step();
        end
        core_done = 4'h0;
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        start = 1'b0;
        step();
        chk("mid_rst_core_start", 32'(core_start), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_irq", 32'(interrupt), 32'd0);
        chk("mid_rst_fault", 32'(core_fault), 32'd0);
        chk("mid_rst_count", 32'(cycle_count), 32'd0);
        reset = 1'b0;
        step();
        run_job("post_reset", 4'hF, 3, 4, 5, 6, 20, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
